// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and hazard tracker placed beside the ID/EX boundary. It keeps a
// short shift pipeline of in-flight register writes, one slot per post-issue
// stage (slot 0 = EX ... slot NUM_STAGES-1 = WB). Each slot records the
// destination register and the first stage at which its result is on the
// stage_data bus. For every read port of the instruction being issued, the
// block picks the youngest matching producer and returns the bypass select and
// the bypassed operand. It raises a load-use style stall when that producer's
// result is not available yet. It also counts stall cycles, saturating at the
// maximum count.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   id_valid       an instruction is presented for issue
//   id_we          the instruction writes a register
//   id_rd          destination register of the instruction
//   id_ready_stage first stage whose stage_data holds the result (ALU 0, load 1)
//   id_rs          source registers, port i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_rs_used     per-port "source actually read"
//   rf_data        register-file read data per port
//   stage_data     result bus of stage k at [k*DATA_W +: DATA_W]
//   ext_hold       global pipeline freeze; all slots keep their contents
//   flush          kill the instruction being issued (no stall, no push)
//   fwd_sel        per port: 0 = register file, k+1 = stage k
//   fwd_data       per-port selected operand
//   stall          issue must be held this cycle
//   stall_cycles   saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int  NUM_READ   = 2,
    parameter int  NUM_STAGES = 3,
    parameter int  REG_ADDR_W = 5,
    parameter int  DATA_W     = 32,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1),
    localparam int RDY_W      = $clog2(NUM_STAGES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    input  logic                           id_we,
    input  logic [REG_ADDR_W-1:0]          id_rd,
    input  logic [RDY_W-1:0]               id_ready_stage,
    input  logic [NUM_READ*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_READ-1:0]            id_rs_used,
    input  logic [NUM_READ*DATA_W-1:0]     rf_data,
    input  logic [NUM_STAGES*DATA_W-1:0]   stage_data,
    input  logic                           ext_hold,
    input  logic                           flush,
    output logic [NUM_READ*SEL_W-1:0]      fwd_sel,
    output logic [NUM_READ*DATA_W-1:0]     fwd_data,
    output logic                           stall,
    output logic [31:0]                    stall_cycles
);

    // In-flight producers: a valid bit plus payload (destination, ready stage).
    logic [NUM_STAGES-1:0]                 slot_valid;
    logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] slot_rd;
    logic [NUM_STAGES-1:0][RDY_W-1:0]      slot_rdy;

    logic [NUM_READ-1:0] port_wait;
    logic                push;
    logic [31:0]         stall_cnt;

    // Bypass selection per read port.
    always_comb begin
        // NOTE: every output of this block gets a default before any condition,
        // so no path leaves a value unassigned and no latch is inferred.
        fwd_sel   = '0;
        fwd_data  = rf_data;
        port_wait = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            // Walk from the oldest slot to the youngest so that the youngest
            // match is written last and wins; an older WAW value never shows.
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (slot_valid[k] && id_rs_used[i] &&
                    (id_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                    (slot_rd[k] == id_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    fwd_sel[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
                    fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
                    port_wait[i]                 = (k < int'(slot_rdy[k]));
                end
            end
        end
    end

    // A flushed instruction never stalls and never enters the tracker.
    assign stall = id_valid && !flush && (|port_wait);
    assign push  = id_valid && id_we && (id_rd != '0) && !stall && !flush;

    // Valid bits: the only state that must clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
        end else if (!ext_hold) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // slot samples its predecessor's pre-edge value in the shift.
            slot_valid <= {slot_valid[NUM_STAGES-2:0], push};
        end
    end

    // NOTE: payload registers are deliberately left out of reset; they are
    // only observed through a set valid bit, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (!ext_hold) begin
            slot_rd  <= {slot_rd[NUM_STAGES-2:0], id_rd};
            slot_rdy <= {slot_rdy[NUM_STAGES-2:0], id_ready_stage};
        end
    end

    // Stall-cycle counter; a held pipeline does not accumulate stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !ext_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;

    // A result must become readable no later than WB.
    a_ready_stage_legal : assert property (
        @(posedge clk) disable iff (!rst_n)
        (id_valid && id_we) |-> (int'(id_ready_stage) < NUM_STAGES)
    );

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
//
// Directed bench for fwd_scoreboard with the default parameters (2 read ports,
// 3 stages). Each cycle the expected outputs are pushed to a queue together
// with the stimulus. They are popped and compared when the combinational
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;

    localparam logic [31:0] S0  = 32'hA5A5_0001;
    localparam logic [31:0] S1  = 32'hB6B6_0002;
    localparam logic [31:0] S2  = 32'hC7C7_0003;
    localparam logic [31:0] RF0 = 32'h1111_0000;
    localparam logic [31:0] RF1 = 32'h2222_0001;
    localparam logic [31:0] MAX = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_we;
    logic [4:0]  id_rd;
    logic [1:0]  id_ready_stage;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [63:0] rf_data;
    logic [95:0] stage_data;
    logic        ext_hold;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic [63:0] fwd_data;
    logic        stall;
    logic [31:0] stall_cycles;

    fwd_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_we          (id_we),
        .id_rd          (id_rd),
        .id_ready_stage (id_ready_stage),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .rf_data        (rf_data),
        .stage_data     (stage_data),
        .ext_hold       (ext_hold),
        .flush          (flush),
        .fwd_sel        (fwd_sel),
        .fwd_data       (fwd_data),
        .stall          (stall),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic        care0;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        stall;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] rdy, input logic [4:0] rs0, input logic u0,
                         input logic [4:0] rs1, input logic u1,
                         input logic hold, input logic fl);
        id_valid       = v;
        id_we          = we;
        id_rd          = rd;
        id_ready_stage = rdy;
        id_rs          = {rs1, rs0};
        id_rs_used     = {u1, u0};
        ext_hold       = hold;
        flush          = fl;
    endtask

    task automatic push_exp(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                            input logic care0, input logic [31:0] d0, input logic [31:0] d1,
                            input logic st, input logic [31:0] cnt);
        exp_t e;
        e.sel0  = s0;
        e.sel1  = s1;
        e.care0 = care0;
        e.d0    = d0;
        e.d1    = d1;
        e.stall = st;
        e.cnt   = cnt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_now();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".sel0"},  32'(fwd_sel[1:0]), 32'(e.sel0));
        check({t, ".sel1"},  32'(fwd_sel[3:2]), 32'(e.sel1));
        if (e.care0) check({t, ".data0"}, fwd_data[31:0], e.d0);
        check({t, ".data1"}, fwd_data[63:32], e.d1);
        check({t, ".stall"}, 32'(stall), 32'(e.stall));
        check({t, ".count"}, stall_cycles, e.cnt);
    endtask

    // One issue cycle: record expectation, sample mid-cycle, advance past edge.
    task automatic cyc(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                       input logic care0, input logic [31:0] d0, input logic [31:0] d1,
                       input logic st, input logic [31:0] cnt);
        push_exp(tag, s0, s1, care0, d0, d1, st, cnt);
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        rf_data    = {RF1, RF0};
        stage_data = {S2, S1, S0};
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        push_exp("reset", 0, 0, 1, RF0, RF1, 0, 0);
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty tracker: no forwarding whatever the inputs.
        drive(1, 1, 3, 0, 3, 1, 3, 1, 0, 0);
        cyc("empty_nofwd", 0, 0, 1, RF0, RF1, 0, 0);
        // ALU chain: r3 forwarded from EX.
        drive(1, 0, 0, 0, 3, 1, 2, 0, 0, 0);
        cyc("alu_chain", 1, 0, 1, S0, RF1, 0, 0);

        // Load-use: exactly one stall cycle, then forward from stage 1.
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc("load_issue", 0, 0, 1, RF0, RF1, 0, 0);
        drive(1, 1, 6, 0, 5, 1, 0, 0, 0, 0);
        cyc("load_use_stall", 1, 0, 0, 32'd0, RF1, 1, 0);
        cyc("load_use_fwd", 2, 0, 1, S1, RF1, 0, 1);
        drive(1, 0, 0, 0, 6, 1, 5, 1, 0, 0);
        cyc("bubble_slot1", 1, 3, 1, S0, S2, 0, 1);

        // WAW: r4 in slots 0 and 2, youngest must win.
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc("waw_w1", 0, 0, 1, RF0, RF1, 0, 1);
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        cyc("waw_mid", 0, 0, 1, RF0, RF1, 0, 1);
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc("waw_w2", 0, 0, 1, RF0, RF1, 0, 1);
        drive(1, 0, 0, 0, 7, 1, 4, 1, 0, 0);
        cyc("waw_priority", 2, 1, 1, S1, S0, 0, 1);

        // r0 is never tracked nor forwarded.
        drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        cyc("r0_write", 0, 0, 1, RF0, RF1, 0, 1);
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        cyc("r0_read", 0, 3, 1, RF0, S2, 0, 1);

        // Unused port matching a load does not stall.
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        cyc("load_r9", 0, 0, 1, RF0, RF1, 0, 1);
        drive(1, 0, 0, 0, 9, 0, 2, 1, 0, 0);
        cyc("unused_port", 0, 0, 1, RF0, RF1, 0, 1);
        drive(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        cyc("idle_fwd", 2, 0, 1, S1, RF1, 0, 1);

        // Load-use under ext_hold: frozen slots, stall held, count unchanged.
        drive(1, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        cyc("load_r10", 0, 0, 1, RF0, RF1, 0, 1);
        drive(1, 0, 0, 0, 10, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("hold_stall", 1, 0, 0, 32'd0, RF1, 1, 1);
        drive(1, 0, 0, 0, 10, 1, 0, 0, 0, 0);
        cyc("hold_release", 1, 0, 0, 32'd0, RF1, 1, 1);
        cyc("hold_fwd", 2, 0, 1, S1, RF1, 0, 2);

        // Flush beats stall and pushes nothing.
        drive(1, 1, 13, 1, 0, 0, 0, 0, 0, 0);
        cyc("load_r13", 0, 0, 1, RF0, RF1, 0, 2);
        drive(1, 1, 12, 0, 13, 1, 0, 0, 0, 1);
        cyc("flush_stall", 1, 0, 0, 32'd0, RF1, 0, 2);
        drive(1, 0, 0, 0, 12, 1, 13, 1, 0, 0);
        cyc("flush_nopush", 0, 2, 1, RF0, S1, 0, 2);

        // Fill all slots, then reset mid-cycle.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("fill1", 0, 0, 1, RF0, RF1, 0, 2);
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc("fill2", 0, 0, 1, RF0, RF1, 0, 2);
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        cyc("fill3", 0, 0, 1, RF0, RF1, 0, 2);
        drive(1, 0, 0, 0, 3, 1, 1, 1, 0, 0);
        push_exp("pre_reset", 1, 3, 0, 32'd0, S2, 1, 2);
        @(negedge clk);
        compare_now();
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("mid_reset", 0, 0, 1, RF0, RF1, 0, 0);
        compare_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_reset_empty", 0, 0, 1, RF0, RF1, 0, 0);

        // Counter saturation from a preloaded value.
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        drive(1, 1, 5, 2, 0, 0, 0, 0, 0, 0);
        cyc("sat_preload", 0, 0, 1, RF0, RF1, 0, 32'hFFFF_FFFE);
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        cyc("sat_stall1", 1, 0, 0, 32'd0, RF1, 1, 32'hFFFF_FFFE);
        cyc("sat_stall2", 2, 0, 0, 32'd0, RF1, 1, MAX);
        cyc("sat_ready", 3, 0, 1, S2, RF1, 0, MAX);
        drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        cyc("sat_load2", 0, 0, 1, RF0, RF1, 0, MAX);
        drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        cyc("sat_stall3", 1, 0, 0, 32'd0, RF1, 1, MAX);
        cyc("sat_at_max", 2, 0, 1, S1, RF1, 0, MAX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
